// File: rtl/det_arbiter.sv
// Round-robin owner of a shared determinant engine: latches the winner's operand,
// runs the engine's level start/done handshake with a watchdog, returns the result.
module det_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_a,
  input  logic         req_b,
  input  logic [1:0]   size_a,
  input  logic [1:0]   size_b,
  input  logic [199:0] matrix_a,
  input  logic [199:0] matrix_b,
  output logic         grant_a,
  output logic         grant_b,
  output logic         done_a,
  output logic         done_b,
  output logic [7:0]   det_a,
  output logic [7:0]   det_b,
  output logic         err_a,
  output logic         err_b,
  output logic [199:0] eng_matrix,
  output logic [1:0]   eng_size,
  output logic         eng_start,
  input  logic         eng_done,
  input  logic [7:0]   eng_det
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] COOL = 2'd3;
  localparam logic [9:0] TIMEOUT_C = 10'(TIMEOUT);

  logic [1:0]   state_r, state_s;
  logic         last_r, last_s;     // 1 = B was served last
  logic         owner_r, owner_s;   // 1 = B owns the engine
  logic [9:0]   cnt_r, cnt_s;
  logic         done_prev_r;
  logic         grant_a_r, grant_a_s, grant_b_r, grant_b_s;
  logic         done_a_r, done_a_s, done_b_r, done_b_s;
  logic [7:0]   det_a_r, det_a_s, det_b_r, det_b_s;
  logic         err_a_r, err_a_s, err_b_r, err_b_s;
  logic [199:0] eng_matrix_r, eng_matrix_s;
  logic [1:0]   eng_size_r, eng_size_s;
  logic         eng_start_r, eng_start_s;
  logic         done_rise_s;
  logic         owner_req_s;

  // A done level already high when RUN begins is stale and must not count as completion.
  assign done_rise_s = eng_done & ~done_prev_r;
  assign owner_req_s = owner_r ? req_b : req_a;

  // Next-state and next-output decode for the arbitration FSM.
  always_comb begin
    state_s      = state_r;
    last_s       = last_r;
    owner_s      = owner_r;
    cnt_s        = cnt_r;
    grant_a_s    = grant_a_r;
    grant_b_s    = grant_b_r;
    done_a_s     = done_a_r;
    done_b_s     = done_b_r;
    det_a_s      = det_a_r;
    det_b_s      = det_b_r;
    err_a_s      = err_a_r;
    err_b_s      = err_b_r;
    eng_matrix_s = eng_matrix_r;
    eng_size_s   = eng_size_r;
    eng_start_s  = eng_start_r;
    case (state_r)
      IDLE: begin
        eng_start_s = 1'b0;
        cnt_s       = 10'd0;
        if (req_a && (!req_b || last_r)) begin
          owner_s      = 1'b0;
          last_s       = 1'b0;
          grant_a_s    = 1'b1;
          err_a_s      = 1'b0;
          eng_matrix_s = matrix_a;
          eng_size_s   = size_a;
          eng_start_s  = 1'b1;
          state_s      = RUN;
        end else if (req_b) begin
          owner_s      = 1'b1;
          last_s       = 1'b1;
          grant_b_s    = 1'b1;
          err_b_s      = 1'b0;
          eng_matrix_s = matrix_b;
          eng_size_s   = size_b;
          eng_start_s  = 1'b1;
          state_s      = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (done_rise_s) begin
          eng_start_s = 1'b0;
          state_s     = HOLD;
          if (owner_r) begin
            det_b_s  = eng_det;
            done_b_s = 1'b1;
          end else begin
            det_a_s  = eng_det;
            done_a_s = 1'b1;
          end
        end else if (cnt_r == TIMEOUT_C) begin
          eng_start_s = 1'b0;
          state_s     = HOLD;
          if (owner_r) begin
            det_b_s  = 8'd0;
            err_b_s  = 1'b1;
            done_b_s = 1'b1;
          end else begin
            det_a_s  = 8'd0;
            err_a_s  = 1'b1;
            done_a_s = 1'b1;
          end
        end else if (!owner_req_s) begin
          eng_start_s = 1'b0;
          grant_a_s   = 1'b0;
          grant_b_s   = 1'b0;
          state_s     = COOL;
        end else begin
          cnt_s = cnt_r + 10'd1;
        end
      end
      HOLD: begin
        eng_start_s = 1'b0;
        if (!owner_req_s) begin
          grant_a_s = 1'b0;
          grant_b_s = 1'b0;
          done_a_s  = 1'b0;
          done_b_s  = 1'b0;
          state_s   = COOL;
        end else begin
          state_s = HOLD;
        end
      end
      COOL: begin
        // Engine must drop its done while start is low before another job may begin.
        eng_start_s = 1'b0;
        if (eng_done) begin
          state_s = COOL;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        eng_start_s = 1'b0;
        grant_a_s   = 1'b0;
        grant_b_s   = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset returns everything to zero with A favoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_r       <= 1'b1;
      owner_r      <= 1'b0;
      cnt_r        <= 10'd0;
      done_prev_r  <= 1'b0;
      grant_a_r    <= 1'b0;
      grant_b_r    <= 1'b0;
      done_a_r     <= 1'b0;
      done_b_r     <= 1'b0;
      det_a_r      <= 8'd0;
      det_b_r      <= 8'd0;
      err_a_r      <= 1'b0;
      err_b_r      <= 1'b0;
      eng_matrix_r <= 200'd0;
      eng_size_r   <= 2'd0;
      eng_start_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      last_r       <= last_s;
      owner_r      <= owner_s;
      cnt_r        <= cnt_s;
      done_prev_r  <= eng_done;
      grant_a_r    <= grant_a_s;
      grant_b_r    <= grant_b_s;
      done_a_r     <= done_a_s;
      done_b_r     <= done_b_s;
      det_a_r      <= det_a_s;
      det_b_r      <= det_b_s;
      err_a_r      <= err_a_s;
      err_b_r      <= err_b_s;
      eng_matrix_r <= eng_matrix_s;
      eng_size_r   <= eng_size_s;
      eng_start_r  <= eng_start_s;
    end
  end

  assign grant_a    = grant_a_r;
  assign grant_b    = grant_b_r;
  assign done_a     = done_a_r;
  assign done_b     = done_b_r;
  assign det_a      = det_a_r;
  assign det_b      = det_b_r;
  assign err_a      = err_a_r;
  assign err_b      = err_b_r;
  assign eng_matrix = eng_matrix_r;
  assign eng_size   = eng_size_r;
  assign eng_start  = eng_start_r;

endmodule

// File: tb/tb_det_arbiter.sv
// Directed bench for det_arbiter: a per-cycle vector table with a hand-driven engine,
// then multi-cycle sequences against a small behavioural engine model.
module tb_det_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_a = 1'b0, req_b = 1'b0;
  logic [1:0]   size_a = 2'd0, size_b = 2'd0;
  logic [199:0] matrix_a = 200'd0, matrix_b = 200'd0;
  logic         grant_a, grant_b, done_a, done_b, err_a, err_b, eng_start;
  logic [7:0]   det_a, det_b;
  logic [199:0] eng_matrix;
  logic [1:0]   eng_size;
  logic         eng_done;
  logic [7:0]   eng_det;

  logic         use_model = 1'b0;
  logic         t_done = 1'b0;
  logic [7:0]   t_det = 8'd0;
  logic         m_done = 1'b0;
  logic [7:0]   m_det = 8'd0;
  int           m_cnt = 0;
  int           eng_lat = 3;
  logic         eng_hang = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign eng_done = use_model ? m_done : t_done;
  assign eng_det  = use_model ? m_det  : t_det;

  det_arbiter #(.TIMEOUT(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .size_a(size_a), .size_b(size_b),
    .matrix_a(matrix_a), .matrix_b(matrix_b),
    .grant_a(grant_a), .grant_b(grant_b), .done_a(done_a), .done_b(done_b),
    .det_a(det_a), .det_b(det_b), .err_a(err_a), .err_b(err_b),
    .eng_matrix(eng_matrix), .eng_size(eng_size), .eng_start(eng_start),
    .eng_done(eng_done), .eng_det(eng_det)
  );

  function automatic logic [199:0] mk2(input logic [7:0] a, b, c, d);
    logic [199:0] m;
    m = 200'd0;
    m[7:0] = a; m[15:8] = b; m[47:40] = c; m[55:48] = d;
    return m;
  endfunction

  function automatic logic [7:0] det2(input logic [199:0] m);
    logic [15:0] a, b, c, d, p;
    a = {8'd0, m[7:0]}; b = {8'd0, m[15:8]}; c = {8'd0, m[47:40]}; d = {8'd0, m[55:48]};
    p = a * d - b * c;
    return p[7:0];
  endfunction

  // Engine model: clears while start is low, answers the top-left 2x2 determinant after eng_lat cycles.
  always @(posedge clk) begin
    if (eng_start !== 1'b1) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else if (!eng_hang && !m_done) begin
      if (m_cnt >= eng_lat - 1) begin
        m_done <= 1'b1;
        m_det  <= det2(eng_matrix);
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [2:0] in;   // {req_a, req_b, eng_done}
    logic [7:0] dt;
    logic [6:0] out;  // {grant_a, grant_b, done_a, done_b, err_a, err_b, eng_start}
    logic [7:0] xa;
    logic [7:0] xb;
  } vec_t;

  localparam int NV = 29;
  vec_t tab [NV];

  function automatic vec_t v(input logic [2:0] in, input logic [7:0] dt, input logic [6:0] out,
                             input logic [7:0] xa, input logic [7:0] xb);
    vec_t r;
    r.in = in; r.dt = dt; r.out = out; r.xa = xa; r.xb = xb;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(input logic side, input string name);
    for (int i = 0; i < 30; i++) begin
      if ((side ? done_b : done_a) === 1'b1) break;
      tick;
    end
    check(name, {199'd0, side ? done_b : done_a}, 200'd1);
  endtask

  initial begin
    logic [199:0] mat1;
    int ja, jb, ng;
    int order [$];
    logic pga, pgb, pst;

    tab[0]  = v(3'b000, 8'h00, 7'b0000000, 8'h00, 8'h00);
    tab[1]  = v(3'b110, 8'h00, 7'b1000001, 8'h00, 8'h00);
    tab[2]  = v(3'b110, 8'h00, 7'b1000001, 8'h00, 8'h00);
    tab[3]  = v(3'b111, 8'h0A, 7'b1010000, 8'h0A, 8'h00);
    tab[4]  = v(3'b111, 8'h0A, 7'b1010000, 8'h0A, 8'h00);
    tab[5]  = v(3'b011, 8'h0A, 7'b0000000, 8'h0A, 8'h00);
    tab[6]  = v(3'b011, 8'h0A, 7'b0000000, 8'h0A, 8'h00);
    tab[7]  = v(3'b010, 8'h00, 7'b0000000, 8'h0A, 8'h00);
    tab[8]  = v(3'b010, 8'h00, 7'b0100001, 8'h0A, 8'h00);
    tab[9]  = v(3'b011, 8'hF3, 7'b0101000, 8'h0A, 8'hF3);
    tab[10] = v(3'b000, 8'h00, 7'b0000000, 8'h0A, 8'hF3);
    tab[11] = v(3'b000, 8'h00, 7'b0000000, 8'h0A, 8'hF3);
    tab[12] = v(3'b111, 8'h00, 7'b1000001, 8'h0A, 8'hF3);
    tab[13] = v(3'b111, 8'h55, 7'b1000001, 8'h0A, 8'hF3);
    tab[14] = v(3'b110, 8'h00, 7'b1000001, 8'h0A, 8'hF3);
    tab[15] = v(3'b010, 8'h00, 7'b0000000, 8'h0A, 8'hF3);
    tab[16] = v(3'b010, 8'h00, 7'b0000000, 8'h0A, 8'hF3);
    for (int i = 17; i <= 24; i++) tab[i] = v(3'b010, 8'h00, 7'b0100001, 8'h0A, 8'hF3);
    tab[25] = v(3'b010, 8'h00, 7'b0101010, 8'h0A, 8'h00);
    tab[26] = v(3'b000, 8'h00, 7'b0000010, 8'h0A, 8'h00);
    tab[27] = v(3'b000, 8'h00, 7'b0000010, 8'h0A, 8'h00);
    tab[28] = v(3'b010, 8'h00, 7'b0100001, 8'h0A, 8'h00);

    matrix_a = mk2(8'd3, 8'd1, 8'd2, 8'd4);
    matrix_b = mk2(8'd9, 8'd2, 8'd3, 8'd1);
    size_b   = 2'd2;

    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    tick;
    check("reset_outputs", {grant_a, grant_b, done_a, done_b, err_a, err_b, eng_start, det_a, det_b, eng_size}, 200'd0);
    check("reset_eng_matrix", eng_matrix, 200'd0);

    for (int i = 0; i < NV; i++) begin
      {req_a, req_b, t_done} = tab[i].in;
      t_det = tab[i].dt;
      tick;
      check($sformatf("vec%0d", i), {grant_a, grant_b, done_a, done_b, err_a, err_b, eng_start, det_a, det_b},
            {tab[i].out, tab[i].xa, tab[i].xb});
    end
    check("vec_latched_b", {eng_matrix, eng_size}, {matrix_b, size_b});

    // Reset in the middle of B's job: everything drops without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_job", {grant_a, grant_b, done_a, done_b, err_a, err_b, eng_start, det_a, det_b, eng_size}, 200'd0);
    check("reset_mid_matrix", eng_matrix, 200'd0);
    req_a = 1'b0; req_b = 1'b0; t_done = 1'b0;
    use_model = 1'b1; eng_lat = 3;
    #13 rst_n = 1'b1;
    tick;

    // Round-robin: both held for three jobs each, A must win the first tie after reset.
    ja = 3; jb = 3; pga = 1'b0; pgb = 1'b0; pst = 1'b0;
    req_a = 1'b1; req_b = 1'b1;
    for (int c = 0; c < 400 && (ja > 0 || jb > 0 || req_a || req_b); c++) begin
      tick;
      if (grant_a && !pga) begin order.push_back(0); check("rr_gap_a", {199'd0, pst}, 200'd0); end
      if (grant_b && !pgb) begin order.push_back(1); check("rr_gap_b", {199'd0, pst}, 200'd0); end
      if (done_a && req_a) begin check("rr_det_a", {err_a, det_a}, {1'b0, 8'd10}); req_a = 1'b0; ja--; end
      else if (!req_a && ja > 0) req_a = 1'b1;
      if (done_b && req_b) begin check("rr_det_b", {err_b, det_b}, {1'b0, 8'd3}); req_b = 1'b0; jb--; end
      else if (!req_b && jb > 0) req_b = 1'b1;
      pga = grant_a; pgb = grant_b; pst = eng_start;
    end
    ng = order.size();
    check("rr_count", 200'(ng), 200'd6);
    for (int i = 0; i < ng; i++) check($sformatf("rr_order%0d", i), 200'(order[i]), 200'(i % 2));
    tick; tick;

    // Single request, engine latency 5.
    eng_lat = 5;
    req_a = 1'b1;
    tick;
    check("single_grant", {grant_a, grant_b, eng_start, eng_size}, {1'b1, 1'b0, 1'b1, 2'd0});
    wait_done(1'b0, "single_done_seen");
    check("single_result", {err_a, det_a}, {1'b0, 8'd10});
    req_a = 1'b0;
    tick;
    check("single_release", {done_a, grant_a}, 200'd0);
    tick; tick;

    // Abort: A drops mid-run while B waits.
    eng_hang = 1'b1;
    req_a = 1'b1;
    tick;
    req_b = 1'b1;
    tick; tick;
    req_a = 1'b0;
    tick;
    check("abort_stop", {grant_a, eng_start, done_a}, 200'd0);
    tick;
    check("abort_cool", {grant_b, done_a}, 200'd0);
    tick;
    check("abort_grant_b", {grant_b, eng_start, done_a}, {1'b1, 1'b1, 1'b0});

    // Timeout on B with the engine never answering.
    for (int i = 0; i < 7; i++) tick;
    check("timeout_not_early", {199'd0, done_b}, 200'd0);
    tick;
    check("timeout_flag", {done_b, err_b, det_b, eng_start}, {1'b1, 1'b1, 8'd0, 1'b0});
    req_b = 1'b0; eng_hang = 1'b0;
    tick; tick; tick;
    req_b = 1'b1;
    tick;
    check("timeout_err_cleared", {grant_b, err_b}, {1'b1, 1'b0});
    wait_done(1'b1, "retry_done_seen");
    check("retry_result", {err_b, det_b}, {1'b0, 8'd3});
    req_b = 1'b0;
    tick; tick; tick;

    // Operand stability on a 5x5 job.
    mat1 = 200'd0;
    for (int i = 0; i < 25; i++) mat1[8*i +: 8] = 8'(i + 1);
    matrix_a = mat1; size_a = 2'd3;
    req_a = 1'b1;
    tick;
    check("stab_latch", {eng_matrix, eng_size}, {mat1, 2'd3});
    matrix_a = ~mat1; size_a = 2'd0;
    tick; tick;
    check("stab_hold", {eng_matrix, eng_size}, {mat1, 2'd3});
    wait_done(1'b0, "stab_done_seen");
    check("stab_result", {eng_matrix, det_a}, {mat1, 8'd251});
    req_a = 1'b0;
    tick; tick; tick;
    req_a = 1'b1;
    tick;
    check("stab_new_latch", {eng_matrix, eng_size}, {~mat1, 2'd0});
    wait_done(1'b0, "stab2_done_seen");
    check("stab2_result", {err_a, det_a}, {1'b0, 8'd251});
    req_a = 1'b0;
    tick; tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/det_arbiter.md
# det_arbiter

Round-robin scheduler that shares one determinant engine (2x2 to 5x5, 8-bit result) between two requesters inside the coprocessor ULA. It latches the winning requester's matrix and size, drives the engine's level start/done handshake, returns the 8-bit determinant to that requester, and enforces a watchdog timeout. It sits between the instruction decoder's two issue ports and the determinant datapath.

## Interface

Parameters:
- `TIMEOUT`, default 1023: maximum number of RUN cycles before abort. Range 1..1023.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_a`, `req_b` in 1 each: level request. Held high until `done_x` is seen.
- `size_a`, `size_b` in 2 each: 0=2x2, 1=3x3, 2=4x4, 3=5x5.
- `matrix_a`, `matrix_b` in 200 each: row r at `[40r +: 40]`, column c at `[8c +: 8]` within a row. Element (0,0) is bits [7:0]. Unused rows/columns are don't-care.
- `grant_a`, `grant_b` out 1 each: requester currently owns the engine.
- `done_a`, `done_b` out 1 each: result valid. Level, held until the matching req drops.
- `det_a`, `det_b` out 8 each: result, valid while `done_x`=1.
- `err_a`, `err_b` out 1 each: timeout flag, valid while `done_x`=1.
- `eng_matrix` out 200: latched operand to the engine.
- `eng_size` out 2: latched size to the engine.
- `eng_start` out 1: engine start, level. The engine idles/clears while low.
- `eng_done` in 1: engine done, level.
- `eng_det` in 8: engine result.

## Operation

- Reset values: all outputs 0 (`eng_matrix`, `eng_size`, `det_x`, `err_x`, `grant_x`, `done_x`, `eng_start`). State IDLE. Round-robin pointer `last` = B, so A wins the first tie.
- **IDLE:**
  - `eng_start`=0.
  - If exactly one req is high, grant it.
  - If both are high, grant the one not equal to `last`.
  - On grant: latch `eng_matrix`/`eng_size` from the winner, set `grant_x`=1, `last`=winner, clear the winner's `err_x`, go to RUN.
- **RUN:**
  - `eng_start`=1. The watchdog counter increments each cycle, starting from 0.
  - Rising edge of `eng_done` (registered `eng_done` & !previous) has priority over timeout: set `det_x`=`eng_det`, `done_x`=1, `eng_start`=0, go to HOLD.
  - Else if counter == `TIMEOUT`: set `det_x`=0, `err_x`=1, `done_x`=1, `eng_start`=0, go to HOLD.
  - Else if the granted req drops (abort): `eng_start`=0, `grant_x`=0, no done, go to COOL.
- **HOLD:**
  - `eng_start`=0. Outputs are held.
  - When the granted req goes low: `done_x`=0, `grant_x`=0, go to COOL.
- **COOL:**
  - `eng_start`=0.
  - Stay while `eng_done`=1. This guarantees the engine sees start low and clears before the next job.
  - Minimum 1 cycle, then IDLE.
- A non-granted requester's outputs never change. `det_x` keeps its last value after `done_x` falls.
- Operand changes on `matrix_x`/`size_x` after grant are ignored; the latched copy is used.
- Arithmetic: none here; `det` is passed through at 8 bits, modulo 256 as produced by the engine.

## Timing

- Req high in cycle t (IDLE): `grant_x`, `eng_matrix`, `eng_size` valid at t+1; `eng_start` high at t+1.
- `eng_done` rising sampled at cycle k: `done_x`/`det_x` valid at k+1, and `eng_start` low at k+1.
- Req low at cycle h (HOLD): `done_x`=0 at h+1. Earliest next grant is at h+3 (COOL 1 cycle, then IDLE decision).
- Back-to-back with both requesters high: service alternates A, B, A, …
- Timeout: `done_x`=1 with `err_x`=1 exactly `TIMEOUT`+1 cycles after `eng_start` rises, if `eng_done` never rises.
- `rst_n` low at any time: all outputs go to 0 immediately. An in-flight engine job is dropped because `eng_start` falls. No result is returned.
- `eng_done` already high on entry to RUN (stale) produces no edge. The engine must clear it; otherwise the job times out.

## Test plan

- **Single request:** A requests a 2x2 [[3,1],[2,4]] with an engine model of latency 5. Expect `grant_a` at t+1, `done_a`=1 and `det_a`=10, `err_a`=0. `done_a` clears 1 cycle after `req_a` drops.
- **Tie / round-robin:** `req_a` and `req_b` rise together, each held for 3 jobs. Expect grant order A, B, A, B, A, B. Each det is returned to the correct port, and `eng_start` is low for ≥1 cycle between jobs.
- **Timeout:** `TIMEOUT`=7, engine never asserts done. Expect `done_b`=1, `err_b`=1, `det_b`=0 at start+8. The next job clears `err_b`.
- **Abort:** `req_a` drops in RUN before `eng_done`. Expect `eng_start`=0 and `grant_a`=0 next cycle, `done_a` never set, and a pending `req_b` granted 2 cycles later.
- **Reset mid-job:** `rst_n` pulsed low during RUN. Expect all outputs 0 asynchronously. After release, A wins the first tie.
- **Operand stability:** `matrix_a` changes after grant (5x5 job). Expect `eng_matrix` unchanged until the next grant.
